gpio_input_capture: RTL and testbench
=====================================

# gpio_input_capture

Input-side companion to the GPIO output peripheral. Synchronises up to WIDTH external input pins into the clock domain and optionally debounces them. Detects per-pin rising and falling edges, latches them into a write-1-to-clear pending register, and raises a level interrupt. Sits on the same memory-mapped peripheral bus as the GPIO block and is read by the CPU through the same read/write strobe interface.

## Interface
- WIDTH, 20: number of input pins, 1..31.
- DEBOUNCE_CYCLES, 4: consecutive disagreeing samples required before the stable value changes, 1..255. Used only with debounce compiled in.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- read  input  1  read strobe.
- write  input  1  write strobe.
- address  input  32  byte address; only address[3:2] decoded.
- write_data  input  32  write data.
- read_data  output  32  read data; combinational; 0 when read is 0.
- pins  input  WIDTH  asynchronous external inputs.
- irq  output  1  level interrupt, registered.

## Operation
- Register map, selected by address[3:2]:
  - 0 VALUE: read-only stable pin value. Writes are ignored.
  - 1 RISE_EN: R/W, per-pin rising-edge enable.
  - 2 FALL_EN: R/W, per-pin falling-edge enable.
  - 3 PENDING: read returns latched edges; a write clears every bit written as 1 (W1C).
- All register fields occupy bits [WIDTH-1:0]. Bits [31:WIDTH] read 0 and are ignored on write.
- Synchroniser: two flops per pin, sync1 then sync2. No logic is applied to sync1.
- Stable value:
  - Without debounce: stable <= sync2 every cycle.
  - With debounce: each pin has a counter of width clog2(DEBOUNCE_CYCLES+1).
    - On a cycle where sync2 != stable, the counter increments.
    - When the increment reaches DEBOUNCE_CYCLES, stable <= sync2 and the counter is cleared.
    - On any cycle where sync2 == stable, the counter is cleared.
- Edge event: generated on the cycle stable is updated.
  - rise[i] = !stable[i] & next[i] & RISE_EN[i].
  - fall[i] = stable[i] & !next[i] & FALL_EN[i].
- PENDING update: pending <= (pending & ~clr) | rise | fall. When set and clear hit the same bit in the same cycle, set wins.
- irq <= |pending_next, so irq is asserted the same cycle a pending bit is set.
- Changing an enable does not alter bits already pending. Clearing an enable masks only future edges.
- Reset (reset == 0 at a clock edge) clears, regardless of read or write: sync1, sync2, stable, all counters, RISE_EN, FALL_EN, PENDING and irq. This includes reset mid-debounce.
- After reset the enables are 0, so a pin held high through reset gives no pending bit.
- read_data is 32'h0 whenever read is 0. Simultaneous read and write: the read returns the pre-write value.

## Timing
- Pin change is sampled into sync1 at edge N and reaches sync2 at N+1.
- Without debounce: stable and the pending bit update at N+2, and irq is 1 after edge N+2.
- With debounce: stable and the pending bit update at N+1+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES sync2 samples produces no change.
- Register writes take effect at the edge where write is 1. A W1C clear drops irq at the same edge if no other bit remains set.
- Reads are zero-latency combinational from the register outputs.

## Configuration
- GPIO_DEBOUNCE_EN defined: per-pin debounce counters are instantiated, and DEBOUNCE_CYCLES applies.
- GPIO_DEBOUNCE_EN undefined: no counters; stable follows sync2 with a one-cycle delay; DEBOUNCE_CYCLES is ignored.

## Structure
- Shared peripheral package:
  - Register offsets VALUE=2'd0, RISE_EN=2'd1, FALL_EN=2'd2, PENDING=2'd3.
  - The bus data width constant, 32.
- One natural sub-module: gpio_input_filter. It holds one pin's synchroniser, optional debounce counter and stable flop, and outputs stable and a change strobe.
- The top level instantiates WIDTH copies of gpio_input_filter and holds the registers, decode and irq.

## Test plan
- Reset hold, then release with pins=20'hFFFFF:
  - VALUE reads 20'hFFFFF after 2+DEBOUNCE_CYCLES cycles.
  - PENDING reads 0 and irq stays 0.
- Write RISE_EN=20'h1, then drive pins[0] 0->1:
  - PENDING=1 and irq=1 at the predicted edge (N+2 without debounce, N+5 with the default DEBOUNCE_CYCLES=4).
  - Write PENDING=1: PENDING=0 and irq=0 at the next cycle.
- Write FALL_EN=20'h80000, then drive pins[19] 1->0: PENDING=20'h80000.
- Write FALL_EN=20'h80000 and drive pins[19] 0->1: PENDING unchanged, no irq.
- With debounce compiled in, DEBOUNCE_CYCLES=4: a 3-cycle pulse on pins[5] gives no VALUE change and no pending bit. A 4-cycle pulse gives VALUE bit 5 = 1.
- A W1C write to bit 2 lands on the same cycle as a new rise on bit 2: PENDING bit 2 remains 1.
- Assert reset mid-debounce, then release with pins stable: no pending bit, and the counters restart from 0.
- Read addresses 0..3 with read=0: read_data=0.
- Write 32'hFFFFFFFF to RISE_EN: it reads back 32'h000FFFFF.

Source files
------------

// File: rtl/gpio_input_capture_pkg.sv
// rtl/gpio_input_capture_pkg.sv - shared peripheral constants for the GPIO input capture block
//
// Purpose: register offsets (decoded from address[3:2]) and the bus data width
// shared by the GPIO input capture top level and anything that talks to it.
package gpio_input_capture_pkg;

  localparam int BUS_DW = 32;

  typedef enum logic [1:0] {
    REG_VALUE   = 2'd0,
    REG_RISE_EN = 2'd1,
    REG_FALL_EN = 2'd2,
    REG_PENDING = 2'd3
  } reg_addr_e;

endpackage

// File: rtl/gpio_input_filter.sv
// rtl/gpio_input_filter.sv - one pin's synchroniser, optional debounce and stable flop
//
// Purpose: brings one asynchronous pin into the clk domain through two flops,
// then tracks a stable value. With GPIO_DEBOUNCE_EN defined, the stable value
// only follows the synchronised pin after DEBOUNCE_CYCLES consecutive
// disagreeing samples; otherwise it follows with a one-cycle delay.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-low reset
//   pin_i     asynchronous pin input
//   stable_o  registered stable pin value
//   change_o  combinational strobe: stable_o toggles at the next clock edge
module gpio_input_filter
`ifdef GPIO_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic stable_o,
  output logic change_o
);

  logic sync1_q;
  logic sync2_q;
  logic stable_q;
  logic stable_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value at which the next disagreeing sample completes the run.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d    = '0;
    change_o = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        change_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign change_o = sync2_q ^ stable_q;
`endif

  assign stable_d = stable_q ^ change_o;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/gpio_input_capture.sv
// rtl/gpio_input_capture.sv - GPIO input synchroniser, edge capture and interrupt
//
// Purpose: synchronises (and with GPIO_DEBOUNCE_EN, debounces) WIDTH input
// pins, latches enabled rising/falling edges into a write-1-to-clear PENDING
// register and drives a registered level interrupt while any bit is pending.
// Register map by address[3:2]: VALUE (RO), RISE_EN, FALL_EN, PENDING (W1C).
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   read        read strobe; read_data is 0 while low
//   write       write strobe
//   address     byte address, only [3:2] decoded
//   write_data  write data, bits [WIDTH-1:0] used
//   read_data   combinational read data
//   pins        asynchronous external inputs
//   irq         registered level interrupt
//
// Build option: GPIO_DEBOUNCE_EN adds per-pin debounce counters and the
// DEBOUNCE_CYCLES parameter.
module gpio_input_capture
  import gpio_input_capture_pkg::*;
#(
  parameter int WIDTH = 20
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [BUS_DW-1:0] address,
  input  logic [BUS_DW-1:0] write_data,
  output logic [BUS_DW-1:0] read_data,
  input  logic [WIDTH-1:0]  pins,
  output logic              irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] change;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;

  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;
  logic             irq_q;

  reg_addr_e        reg_sel;
  logic             unused_bits;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_input_filter
`ifdef GPIO_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_filter (
        .clk      (clk),
        .reset    (reset),
        .pin_i    (pins[i]),
        .stable_o (stable[i]),
        .change_o (change[i])
      );
  end

  assign reg_sel = reg_addr_e'(address[3:2]);

  // change marks the edge where stable flips, so the old stable value tells
  // the direction of the edge.
  assign rise = ~stable & change & rise_en_q;
  assign fall =  stable & change & fall_en_q;

  assign clr = (write && reg_sel == REG_PENDING) ? write_data[WIDTH-1:0] : '0;

  // Set after clear so a new edge wins over a simultaneous W1C.
  assign pending_d = (pending_q & ~clr) | rise | fall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (write && reg_sel == REG_RISE_EN) begin
        rise_en_q <= write_data[WIDTH-1:0];
      end
      if (write && reg_sel == REG_FALL_EN) begin
        fall_en_q <= write_data[WIDTH-1:0];
      end
      pending_q <= pending_d;
      irq_q     <= |pending_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    read_data = '0;
    if (read) begin
      case (reg_sel)
        REG_VALUE:   read_data[WIDTH-1:0] = stable;
        REG_RISE_EN: read_data[WIDTH-1:0] = rise_en_q;
        REG_FALL_EN: read_data[WIDTH-1:0] = fall_en_q;
        REG_PENDING: read_data[WIDTH-1:0] = pending_q;
        default:     read_data = '0;
      endcase
    end
  end

  assign unused_bits = ^{address[BUS_DW-1:4], address[1:0], write_data[BUS_DW-1:WIDTH]};

endmodule

// File: tb/tb_gpio_input_capture.sv
// tb/tb_gpio_input_capture.sv - scoreboard bench for gpio_input_capture
`timescale 1ns/1ps
module tb_gpio_input_capture;
  import gpio_input_capture_pkg::*;

  localparam int W = 20;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 1;
`endif
  // Edges from driving a pin change to stable/PENDING updating.
  localparam int LAT = 2 + DB;

  logic          clk = 1'b0;
  logic          reset;
  logic          read;
  logic          write;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic [W-1:0]  pins;
  logic          irq;

  typedef struct {
    logic [31:0] data;
    logic        irq;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  gpio_input_capture #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .read       (read),
    .write      (write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .pins       (pins),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input reg_addr_e a, input logic [31:0] d, input logic i, input string nm);
    address = {28'h0, a, 2'b00};
    read    = 1'b1;
    exp_q.push_back('{data: d, irq: i, name: nm});
    step(1);
    read    = 1'b0;
  endtask

  task automatic wr(input reg_addr_e a, input logic [31:0] d);
    address    = {28'h0, a, 2'b00};
    write_data = d;
    write      = 1'b1;
    step(1);
    write      = 1'b0;
  endtask

  task automatic rdwr(input reg_addr_e a, input logic [31:0] wd, input logic [31:0] d,
                      input logic i, input string nm);
    address    = {28'h0, a, 2'b00};
    write_data = wd;
    write      = 1'b1;
    read       = 1'b1;
    exp_q.push_back('{data: d, irq: i, name: nm});
    step(1);
    write      = 1'b0;
    read       = 1'b0;
  endtask

  // Monitor: every read cycle consumes one scoreboard entry; idle cycles
  // must show read_data = 0.
  always @(negedge clk) begin
    if (read === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_read: read_data=%h with empty scoreboard", read_data);
      end else begin
        mon_e = exp_q.pop_front();
        n_chk++;
        if (read_data !== mon_e.data) begin
          n_fail++;
          $display("FAIL %s data: got %h expected %h", mon_e.name, read_data, mon_e.data);
        end
        n_chk++;
        if (irq !== mon_e.irq) begin
          n_fail++;
          $display("FAIL %s irq: got %b expected %b", mon_e.name, irq, mon_e.irq);
        end
      end
    end else if (read === 1'b0) begin
      n_chk++;
      if (read_data !== 32'h0) begin
        n_fail++;
        $display("FAIL idle_read_data: got %h expected 00000000", read_data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    pins       = 20'hFFFFF;
    step(3);
    rd(REG_VALUE,   32'h0, 1'b0, "rst_value");
    rd(REG_PENDING, 32'h0, 1'b0, "rst_pending");

    // Release with all pins high: VALUE settles LAT edges later, no pending.
    reset = 1'b1;
    step(LAT - 1);
    rd(REG_VALUE,   32'h0,     1'b0, "value_pre_settle");
    rd(REG_VALUE,   32'hFFFFF, 1'b0, "value_settled");
    rd(REG_PENDING, 32'h0,     1'b0, "pend_after_rst");

    // Rising edge on pin 0 with exact latency, then W1C.
    pins[0] = 1'b0;
    step(LAT + 1);
    wr(REG_RISE_EN, 32'h1);
    pins[0] = 1'b1;
    step(LAT - 1);
    rd(REG_PENDING, 32'h0, 1'b0, "rise0_early");
    rd(REG_PENDING, 32'h1, 1'b1, "rise0_set");
    wr(REG_PENDING, 32'h1);
    rd(REG_PENDING, 32'h0, 1'b0, "rise0_clr");

    // Falling edge on pin 19.
    wr(REG_FALL_EN, 32'h80000);
    pins[19] = 1'b0;
    step(LAT);
    rd(REG_PENDING, 32'h80000, 1'b1, "fall19_set");
    wr(REG_PENDING, 32'h80000);
    rd(REG_PENDING, 32'h0, 1'b0, "fall19_clr");

    // Rise on pin 19 with only FALL_EN set: ignored.
    pins[19] = 1'b1;
    step(LAT + 1);
    rd(REG_PENDING, 32'h0,     1'b0, "rise19_masked");
    rd(REG_VALUE,   32'hFFFFF, 1'b0, "value_all_high");

    // Short pulses on pin 5.
    wr(REG_RISE_EN, 32'h21);
    pins[5] = 1'b0;
    step(LAT + 1);
    rd(REG_VALUE, 32'hFFFDF, 1'b0, "pin5_low");
`ifdef GPIO_DEBOUNCE_EN
    pins[5] = 1'b1;
    step(3);
    pins[5] = 1'b0;
    step(LAT + 2);
    rd(REG_VALUE,   32'hFFFDF, 1'b0, "glitch3_value");
    rd(REG_PENDING, 32'h0,     1'b0, "glitch3_pend");
    pins[5] = 1'b1;
    step(4);
    pins[5] = 1'b0;
    step(1);
    rd(REG_VALUE,   32'hFFFDF, 1'b0, "pulse4_pre");
    rd(REG_VALUE,   32'hFFFFF, 1'b1, "pulse4_value");
    rd(REG_PENDING, 32'h20,    1'b1, "pulse4_pend");
    step(3);
    rd(REG_VALUE,   32'hFFFDF, 1'b1, "pulse4_back");
`else
    pins[5] = 1'b1;
    step(1);
    pins[5] = 1'b0;
    step(1);
    rd(REG_PENDING, 32'h0,     1'b0, "glitch1_early");
    rd(REG_VALUE,   32'hFFFFF, 1'b1, "glitch1_value");
    rd(REG_PENDING, 32'h20,    1'b1, "glitch1_pend");
    rd(REG_VALUE,   32'hFFFDF, 1'b1, "glitch1_back");
`endif
    wr(REG_PENDING, 32'h20);
    rd(REG_PENDING, 32'h0, 1'b0, "pin5_clr");

    // W1C on bit 2 lands on the same edge as a new rise on bit 2.
    wr(REG_RISE_EN, 32'h25);
    pins[2] = 1'b0;
    step(LAT + 1);
    pins[2] = 1'b1;
    step(LAT);
    rd(REG_PENDING, 32'h4, 1'b1, "rise2_set");
    pins[2] = 1'b0;
    step(LAT + 1);
    pins[2] = 1'b1;
    step(LAT - 1);
    wr(REG_PENDING, 32'h4);
    rd(REG_PENDING, 32'h4, 1'b1, "w1c_collide");
    wr(REG_PENDING, 32'h4);
    rd(REG_PENDING, 32'h0, 1'b0, "rise2_clr");

    // Reset while pin 2 is mid-debounce and pin 0 is pending.
    wr(REG_FALL_EN, 32'h80005);
    pins[0] = 1'b0;
    step(LAT);
    rd(REG_PENDING, 32'h1, 1'b1, "fall0_set");
    pins[2] = 1'b0;
    step(3);
    reset = 1'b0;
    step(1);
    rd(REG_PENDING, 32'h0, 1'b0, "rst_mid_pend");
    reset = 1'b1;
    step(LAT - 1);
    rd(REG_VALUE,   32'h0,     1'b0, "rst2_pre");
    rd(REG_VALUE,   32'hFFFDA, 1'b0, "rst2_value");
    rd(REG_RISE_EN, 32'h0,     1'b0, "rst2_rise_en");
    rd(REG_FALL_EN, 32'h0,     1'b0, "rst2_fall_en");
    rd(REG_PENDING, 32'h0,     1'b0, "rst2_pend");

    // Every address with read low.
    for (int a = 0; a < 4; a++) begin
      address = 32'(a) << 2;
      step(1);
    end

    // Upper bits masked, read-during-write, VALUE read-only.
    wr(REG_RISE_EN, 32'hFFFFFFFF);
    rd(REG_RISE_EN, 32'h000FFFFF, 1'b0, "rise_en_mask");
    rdwr(REG_RISE_EN, 32'h0, 32'h000FFFFF, 1'b0, "rdwr_pre");
    rd(REG_RISE_EN, 32'h0, 1'b0, "rdwr_post");
    wr(REG_VALUE, 32'h0);
    rd(REG_VALUE, 32'hFFFDA, 1'b0, "value_ro");

    step(2);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
